// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared encodings for the refill arbiter: FSM states,
//               requester IDs and the default refill burst length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_GNT_IC = 2'd1;
    localparam logic [1:0] C_ST_GNT_DC = 2'd2;

    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_DC = 1'b1;

    localparam int C_BURST_LEN_DEF = 4;

    function automatic logic [1:0] grant_state(input logic id);
        return (id == REQ_DC) ? C_ST_GNT_DC : C_ST_GNT_IC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_arb_pick.sv
// ============================================================================
// Module      : riscv_arb_pick
// Description : Winner selection between icache and dcache requests.
//               RISCV_REFILL_ARB_RR_EN selects round-robin on collisions,
//               otherwise dcache has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_arb_pick
    import riscv_pkg::*;
(
    input  logic req_ic,
    input  logic req_dc,
    input  logic last_owner,
    output logic winner
);

`ifdef RISCV_REFILL_ARB_RR_EN
    always_comb begin
        winner = REQ_DC;
        if (req_ic && req_dc) begin
            winner = (last_owner == REQ_DC) ? REQ_IC : REQ_DC;
        end else if (req_ic) begin
            winner = REQ_IC;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = last_owner;

    always_comb begin
        winner = REQ_DC;
        if (req_ic && !req_dc) begin
            winner = REQ_IC;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/riscv_refill_arbiter.sv
// ============================================================================
// Module      : riscv_refill_arbiter
// Description : Arbitrates icache refills and dcache bursts onto a single
//               memory port; the grant is held for a whole burst.
//               Optional macro: RISCV_REFILL_ARB_RR_EN (round-robin on ties).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_refill_arbiter
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = C_BURST_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    srst_n,
    input  logic                    ic_req,
    input  logic [31:0]             ic_addr,
    output logic                    ic_ack,
    output logic [2*DATA_WIDTH-1:0] ic_rdata,
    input  logic                    dc_req,
    input  logic                    dc_we,
    input  logic [31:0]             dc_addr,
    input  logic [2*DATA_WIDTH-1:0] dc_wdata,
    output logic                    dc_ack,
    output logic [2*DATA_WIDTH-1:0] dc_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [2*DATA_WIDTH-1:0] mem_wdata,
    input  logic [2*DATA_WIDTH-1:0] mem_rdata,
    input  logic                    mem_ack
);

    localparam int                 C_CNT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [C_CNT_W-1:0] c_cnt_last = C_CNT_W'(BURST_LEN - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [C_CNT_W-1:0] r_beat_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic               r_last_owner;
    logic               w_last_nxt;
    logic               w_winner;
    logic               w_owner_req;

    riscv_arb_pick u_pick (
        .req_ic     (ic_req),
        .req_dc     (dc_req),
        .last_owner (r_last_owner),
        .winner     (w_winner)
    );

    assign w_owner_req = (r_state == C_ST_GNT_IC) ? ic_req :
                         (r_state == C_ST_GNT_DC) ? dc_req : 1'b0;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_state      <= C_ST_IDLE;
            r_beat_cnt   <= '0;
            r_last_owner <= REQ_DC;
        end else begin
            r_state      <= w_state_nxt;
            r_beat_cnt   <= w_cnt_nxt;
            r_last_owner <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_beat_cnt;
        w_last_nxt  = r_last_owner;
        case (r_state)
            C_ST_IDLE: begin
                if (ic_req || dc_req) begin
                    w_state_nxt = grant_state(w_winner);
                    w_last_nxt  = w_winner;
                end
            end
            C_ST_GNT_IC, C_ST_GNT_DC: begin
                // A dropped request aborts the burst and swallows any coincident ack.
                if (!w_owner_req) begin
                    w_state_nxt = C_ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (mem_ack) begin
                    if (r_beat_cnt == c_cnt_last) begin
                        w_state_nxt = C_ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_beat_cnt + C_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = C_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are forced to their idle values while reset is asserted.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ic_ack    = 1'b0;
        dc_ack    = 1'b0;
        if (srst_n) begin
            case (r_state)
                C_ST_GNT_IC: begin
                    mem_req  = ic_req;
                    mem_addr = ic_addr;
                    ic_ack   = ic_req & mem_ack;
                end
                C_ST_GNT_DC: begin
                    mem_req   = dc_req;
                    mem_we    = dc_we;
                    mem_addr  = dc_addr;
                    mem_wdata = dc_wdata;
                    dc_ack    = dc_req & mem_ack;
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

    assign ic_rdata = mem_rdata;
    assign dc_rdata = mem_rdata;

endmodule

`default_nettype wire
